floo_tcdm_req_throttle: RTL

Sits between a core-side TCDM initiator port and the TCDM-to-NoC network interface: feeds its request input and consumes its response output.
- Bounds outstanding TCDM requests to MaxOutstanding.
- Registers the request path.
- Buffers responses in a FIFO sized so the NoC response channel is never back-pressured, which removes response-path deadlock.

---
 rtl/floo_pkg.sv | 7 +
 rtl/floo_tcdm_rsp_fifo.sv | 65 ++++++
 rtl/floo_tcdm_req_throttle.sv | 114 +++++++++++
 3 files changed

// File: rtl/floo_pkg.sv
// Shared constants for the FlooNoC TCDM adapters.
// The TCDM request/response structs come from the TCDM typedef macros, not from here.
package floo_pkg;

    localparam int unsigned StallCntWidth = 32;

endpackage

// File: rtl/floo_tcdm_rsp_fifo.sv
// Registered (non fall-through) response FIFO used by floo_tcdm_req_throttle.
// An entry pushed at cycle N shows up on data_o at cycle N+1.
module floo_tcdm_rsp_fifo #(
    parameter int unsigned Depth  = 4,
    parameter type         data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  data_t data_i,
    output logic  full_o,
    input  logic  pop_i,
    output data_t data_o,
    output logic  empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    data_t                mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 push_en;
    logic                 pop_en;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_en)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and the count define validity.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && full_o))
                else $error("floo_tcdm_rsp_fifo: push while full");
        end
    end

endmodule

// File: rtl/floo_tcdm_req_throttle.sv
// Bounds outstanding TCDM requests, registers the request path and buffers responses.
// Optional stall counter: define FLOO_TCDM_THROTTLE_STALL_CNT_EN.
module floo_tcdm_req_throttle
    import floo_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter type         tcdm_req_t     = logic,
    parameter type         tcdm_rsp_t     = logic,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  tcdm_req_t                in_req_i,
    input  logic                     in_req_valid_i,
    output logic                     in_req_ready_o,
    output tcdm_rsp_t                in_rsp_o,
    output logic                     in_rsp_valid_o,
    input  logic                     in_rsp_ready_i,
    output tcdm_req_t                out_req_o,
    output logic                     out_req_valid_o,
    input  logic                     out_req_ready_i,
    input  tcdm_rsp_t                out_rsp_i,
    input  logic                     out_rsp_valid_i,
    output logic                     out_rsp_ready_o,
    output logic [CntWidth-1:0]      outstanding_o,
    output logic                     idle_o,
    output logic [StallCntWidth-1:0] stall_cnt_o
);

    logic [CntWidth-1:0] credit_q;
    tcdm_req_t           req_q;
    logic                req_valid_q;
    logic                credit_full;
    logic                in_req_hs;
    logic                in_rsp_hs;
    logic                out_req_hs;
    logic                fifo_full;
    logic                fifo_empty;

    // Ready depends on registered credit only, so a response pop frees a slot one cycle later.
    assign credit_full    = (credit_q == CntWidth'(MaxOutstanding));
    assign in_req_ready_o = (~req_valid_q | out_req_ready_i) & ~credit_full;
    assign in_req_hs      = in_req_valid_i & in_req_ready_o;
    assign in_rsp_hs      = in_rsp_valid_o & in_rsp_ready_i;
    assign out_req_hs     = req_valid_q & out_req_ready_i;

    assign out_req_o       = req_q;
    assign out_req_valid_o = req_valid_q;
    assign outstanding_o   = credit_q;
    assign idle_o          = (credit_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q <= '0;
        end else begin
            case ({in_req_hs, in_rsp_hs})
                2'b10:   credit_q <= credit_q + 1'b1;
                2'b01:   credit_q <= credit_q - 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
        end else if (in_req_hs) begin
            req_valid_q <= 1'b1;
        end else if (out_req_hs) begin
            req_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_req_hs) req_q <= in_req_i;
    end

    // Depth equals the credit limit, so the NI response channel is never back-pressured.
    assign out_rsp_ready_o = ~fifo_full;
    assign in_rsp_valid_o  = ~fifo_empty;

    floo_tcdm_rsp_fifo #(
        .Depth  (MaxOutstanding),
        .data_t (tcdm_rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (out_rsp_valid_i),
        .data_i  (out_rsp_i),
        .full_o  (fifo_full),
        .pop_i   (in_rsp_ready_i),
        .data_o  (in_rsp_o),
        .empty_o (fifo_empty)
    );

`ifdef FLOO_TCDM_THROTTLE_STALL_CNT_EN
    logic [StallCntWidth-1:0] stall_cnt_q;

    // Only credit-limited stalls count; a back-pressured request register does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (in_req_valid_i && !in_req_ready_o && credit_full
                     && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
